spi_slave_cmd_decoder: RTL

Byte-level command decoder in the obi_aclk domain, directly upstream of the SPI-to-OBI plug. It consumes bytes already deserialised and synchronised from the SPI shift register, then decodes command, address, wrap-length and write-data phases. It drives the plug's rxtx_addr/rxtx_addr_valid, start_tx, wrap_length and rx_data/rx_valid/rx_ready interface. The read-data return path (tx_*) bypasses this block.

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_slave_cmd_decoder_if.sv | 29 ++
 rtl/spi_slave_word_assembler.sv | 75 +++++++
 rtl/spi_slave_cmd_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared opcodes, FSM state encoding and phase lengths for the SPI slave
// command decoder.
package spi_slave_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRAP  = 8'h11;

    localparam int ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DUMMY,
        WDATA,
        WRAP,
        HOLD,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_slave_cmd_decoder_if.sv
// Byte-stream input and SPI-to-OBI plug signals of the command decoder.
interface spi_slave_cmd_decoder_if #(
    parameter int OBI_ADDR_WIDTH = 32
);
    logic                      cs;
    logic [7:0]                byte_data;
    logic                      byte_valid;
    logic [OBI_ADDR_WIDTH-1:0] rxtx_addr;
    logic                      rxtx_addr_valid;
    logic                      start_tx;
    logic [15:0]               wrap_length;
    logic [31:0]               rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      err_overflow;
    logic                      err_cmd;

    modport slave (
        input  cs, byte_data, byte_valid, rx_ready,
        output rxtx_addr, rxtx_addr_valid, start_tx, wrap_length,
               rx_data, rx_valid, err_overflow, err_cmd
    );

    modport master (
        output cs, byte_data, byte_valid, rx_ready,
        input  rxtx_addr, rxtx_addr_valid, start_tx, wrap_length,
               rx_data, rx_valid, err_overflow, err_cmd
    );
endinterface

// File: rtl/spi_slave_word_assembler.sv
// Packs write-data bytes MSB first into 32-bit words and holds each word in a
// valid/ready output register; words arriving while the register is stuck are dropped.
module spi_slave_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    input  logic        clear_i,
    input  logic        clr_ovf_i,
    input  logic        rx_ready_i,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        err_overflow_o
);
    logic [23:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end

        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_en_i) begin
            if (cnt_q == 2'd3) begin
                cnt_d = '0;
                // A word can load over one that is being accepted this same cycle.
                if (!valid_q || rx_ready_i) begin
                    data_d  = {sr_q, byte_i};
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                sr_d  = {sr_q[15:0], byte_i};
                cnt_d = cnt_q + 2'd1;
            end
        end

        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign err_overflow_o = ovf_q;

endmodule

// File: rtl/spi_slave_cmd_decoder.sv
// Byte-level command decoder feeding the SPI-to-OBI plug: decodes the command,
// address, dummy, wrap-length and write-data phases of each chip-select frame.
module spi_slave_cmd_decoder
    import spi_slave_pkg::*;
#(
    parameter int OBI_ADDR_WIDTH = 32,
    parameter int DUMMY_BYTES    = 1
) (
    input  logic                    obi_aclk,
    input  logic                    obi_aresetn,
    spi_slave_cmd_decoder_if.slave  bus
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = (DUMMY_BYTES == 0) ? '0 : CNT_W'(DUMMY_BYTES - 1);
    localparam bit               NO_DUMMY   = (DUMMY_BYTES == 0);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      is_write_q, is_write_d;
    logic [23:0]               sr_q, sr_d;
    logic [OBI_ADDR_WIDTH-1:0] rxtx_addr_q, rxtx_addr_d;
    logic                      addr_valid_q, addr_valid_d;
    logic                      start_tx_q, start_tx_d;
    logic [15:0]               wrap_len_q, wrap_len_d;
    logic                      err_cmd_q, err_cmd_d;

    logic                      byte_acc;
    logic [31:0]               addr_word;
    logic [OBI_ADDR_WIDTH-1:0] addr_conv;

    // Deselect takes priority over any byte presented in the same cycle.
    assign byte_acc  = bus.byte_valid & ~bus.cs;
    assign addr_word = {sr_q, bus.byte_data};

    generate
        if (OBI_ADDR_WIDTH > 32) begin : g_addr_ext
            assign addr_conv = {{(OBI_ADDR_WIDTH-32){1'b0}}, addr_word};
        end else if (OBI_ADDR_WIDTH == 32) begin : g_addr_eq
            assign addr_conv = addr_word;
        end else begin : g_addr_trunc
            assign addr_conv = addr_word[OBI_ADDR_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
        if (!obi_aresetn) begin
            state_q      <= CMD;
            cnt_q        <= '0;
            is_write_q   <= 1'b0;
            sr_q         <= '0;
            rxtx_addr_q  <= '0;
            addr_valid_q <= 1'b0;
            start_tx_q   <= 1'b0;
            wrap_len_q   <= '0;
            err_cmd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_write_q   <= is_write_d;
            sr_q         <= sr_d;
            rxtx_addr_q  <= rxtx_addr_d;
            addr_valid_q <= addr_valid_d;
            start_tx_q   <= start_tx_d;
            wrap_len_q   <= wrap_len_d;
            err_cmd_q    <= err_cmd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_write_d   = is_write_q;
        sr_d         = sr_q;
        rxtx_addr_d  = rxtx_addr_q;
        addr_valid_d = 1'b0;
        start_tx_d   = 1'b0;
        wrap_len_d   = wrap_len_q;
        err_cmd_d    = 1'b0;

        if (bus.cs) begin
            state_d = CMD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CMD: begin
                    if (byte_acc) begin
                        cnt_d = '0;
                        case (bus.byte_data)
                            CMD_WRITE: begin state_d = ADDR; is_write_d = 1'b1; end
                            CMD_READ:  begin state_d = ADDR; is_write_d = 1'b0; end
                            CMD_WRAP:  state_d = WRAP;
                            default: begin
                                err_cmd_d = 1'b1;
                                state_d   = IGNORE;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_acc) begin
                        sr_d = {sr_q[15:0], bus.byte_data};
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d        = '0;
                            rxtx_addr_d  = addr_conv;
                            addr_valid_d = 1'b1;
                            state_d      = is_write_q ? WDATA : DUMMY;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DUMMY: begin
                    // With no dummy bytes this state only spaces start_tx one cycle after the address.
                    if (NO_DUMMY) begin
                        start_tx_d = 1'b1;
                        state_d    = HOLD;
                    end else if (byte_acc) begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d      = '0;
                            start_tx_d = 1'b1;
                            state_d    = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                WRAP: begin
                    if (byte_acc) begin
                        sr_d = {sr_q[15:0], bus.byte_data};
                        if (cnt_q == CNT_W'(1)) begin
                            cnt_d      = '0;
                            wrap_len_d = {sr_q[7:0], bus.byte_data};
                            state_d    = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                WDATA, HOLD, IGNORE: begin
                end
                default: state_d = CMD;
            endcase
        end
    end

    logic        asm_byte_en;
    logic        asm_clr_ovf;
    logic [31:0] asm_rx_data;
    logic        asm_rx_valid;
    logic        asm_err_ovf;

    assign asm_byte_en = byte_acc && (state_q == WDATA);
    assign asm_clr_ovf = byte_acc && (state_q == CMD) && (bus.byte_data == CMD_WRITE);

    spi_slave_word_assembler u_word_asm (
        .clk            (obi_aclk),
        .rst_n          (obi_aresetn),
        .byte_en_i      (asm_byte_en),
        .byte_i         (bus.byte_data),
        .clear_i        (bus.cs),
        .clr_ovf_i      (asm_clr_ovf),
        .rx_ready_i     (bus.rx_ready),
        .rx_data_o      (asm_rx_data),
        .rx_valid_o     (asm_rx_valid),
        .err_overflow_o (asm_err_ovf)
    );

    assign bus.rxtx_addr       = rxtx_addr_q;
    assign bus.rxtx_addr_valid = addr_valid_q;
    assign bus.start_tx        = start_tx_q;
    assign bus.wrap_length     = wrap_len_q;
    assign bus.err_cmd         = err_cmd_q;
    assign bus.rx_data         = asm_rx_data;
    assign bus.rx_valid        = asm_rx_valid;
    assign bus.err_overflow    = asm_err_ovf;

endmodule
